// File: rtl/hp_cvtws_seq.sv
// hp_cvtws_seq: sequential bfloat-style float to signed INTn integer converter
//   Ports: clk, rst_n (async active-low); in_valid/in_ready/in = float operand {sign,exp,frac};
//   out_valid/out_ready/out = signed integer result; inexact, invalid = IEEE flags valid with out_valid.
//   Optional macro HP_CVTWS_RTZ_EN adds input rtz (sampled at accept) selecting round-toward-zero.
module hp_cvtws_seq #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INTn-1:0]      out,
  output logic                 inexact,
  output logic                 invalid
`ifdef HP_CVTWS_RTZ_EN
  ,
  input  logic                 rtz
`endif
);
  localparam int AW = INTn + NSIG + 1;
  localparam int CW = $clog2(INTn) + 1;
  localparam int EW = NEXP + 2;
  localparam int BIAS = 2 ** (NEXP - 1) - 1;
  localparam logic signed [EW-1:0] E_MAX = EW'(INTn - 1);
  localparam logic signed [EW-1:0] E_M1 = EW'(-1);
  localparam logic [INTn-1:0] MAXV = {1'b0, {(INTn-1){1'b1}}};
  localparam logic [INTn-1:0] MINV = {1'b1, {(INTn-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t r_state, w_state_n;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic r_sign, r_sticky, r_right, r_inexact, r_invalid;
  logic [INTn-1:0] r_out;

  logic w_sign, w_rtz;
  logic [NEXP-1:0] w_exp;
  logic [NSIG-1:0] w_frac;
  logic signed [EW-1:0] w_e;
  logic w_sp, w_sp_inx, w_sp_inv;
  logic [INTn-1:0] w_sp_out;
  logic [AW-1:0] w_int, w_mag;
  logic w_guard, w_rest, w_inc, w_ovf;
  logic [INTn-1:0] w_res;

`ifdef HP_CVTWS_RTZ_EN
  logic r_rtz;
  assign w_rtz = r_rtz;
`else
  assign w_rtz = 1'b0;
`endif

  assign w_sign = in[NEXP+NSIG];
  assign w_exp  = in[NEXP+NSIG-1:NSIG];
  assign w_frac = in[NSIG-1:0];
  assign w_e    = $signed({2'b00, w_exp}) - $signed(EW'(BIAS));

  // Operands whose result is known without shifting go straight to DONE.
  always_comb begin
    w_sp = 1'b1;
    w_sp_out = '0;
    w_sp_inx = 1'b0;
    w_sp_inv = 1'b0;
    if (w_exp == '0) begin
      w_sp_inx = |w_frac;
    end else if (&w_exp) begin
      w_sp_inv = 1'b1;
      w_sp_out = (w_sign && w_frac == '0) ? MINV : MAXV;
    end else if (w_e >= E_MAX) begin
      // -2^(INTn-1) is the one representable value at this exponent
      w_sp_inv = !(w_e == E_MAX && w_sign && w_frac == '0);
      w_sp_out = w_sign ? MINV : MAXV;
    end else if (w_e < E_M1) begin
      w_sp_inx = 1'b1;
    end else begin
      w_sp = 1'b0;
    end
  end

  // Round-to-nearest-even on the aligned accumulator; the magnitude limit
  // differs by sign because the negative range is one larger.
  assign w_int   = r_acc >> NSIG;
  assign w_guard = r_acc[NSIG-1];
  assign w_rest  = |r_acc[NSIG-2:0] | r_sticky;
  assign w_inc   = !w_rtz & w_guard & (w_rest | w_int[0]);
  assign w_mag   = w_int + AW'(w_inc);
  assign w_ovf   = w_mag > (r_sign ? AW'(MINV) : AW'(MAXV));
  assign w_res   = INTn'(r_sign ? -w_mag : w_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:  if (in_valid) w_state_n = w_sp ? DONE : (w_e == '0 ? ROUND : SHIFT);
      SHIFT: if (r_cnt == CW'(1)) w_state_n = ROUND;
      ROUND: w_state_n = DONE;
      DONE:  if (out_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sign <= 1'b0;
      r_sticky <= 1'b0;
      r_right <= 1'b0;
      r_out <= '0;
      r_inexact <= 1'b0;
      r_invalid <= 1'b0;
`ifdef HP_CVTWS_RTZ_EN
      r_rtz <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign <= w_sign;
          r_acc <= AW'({1'b1, w_frac});
          r_sticky <= 1'b0;
          r_right <= w_e[EW-1];
          r_cnt <= w_e[EW-1] ? CW'(1) : CW'(w_e);
`ifdef HP_CVTWS_RTZ_EN
          r_rtz <= rtz;
`endif
          if (w_sp) begin
            r_out <= w_sp_out;
            r_inexact <= w_sp_inx;
            r_invalid <= w_sp_inv;
          end
        end
        SHIFT: begin
          r_acc <= r_right ? r_acc >> 1 : r_acc << 1;
          r_sticky <= r_sticky | (r_right & r_acc[0]);
          r_cnt <= r_cnt - 1'b1;
        end
        ROUND: begin
          r_out <= w_ovf ? (r_sign ? MINV : MAXV) : w_res;
          r_inexact <= !w_ovf & (w_guard | w_rest);
          r_invalid <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  assign out = r_out;
  assign inexact = r_inexact;
  assign invalid = r_invalid;
endmodule

// File: tb/tb_hp_cvtws_seq.sv
// tb_hp_cvtws_seq: scoreboard bench for hp_cvtws_seq with directed float vectors
module tb_hp_cvtws_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, rtz = 1'b0;
  logic [15:0] in = '0;
  logic in_ready, out_valid, inexact, invalid;
  logic [31:0] out;

  typedef struct {logic [31:0] o; logic x; logic v; int lat; int t;} exp_t;
  typedef struct {logic [15:0] f; logic [31:0] o; logic x; logic v; int lat;} vec_t;

  exp_t q[$];
  exp_t cur;
  bit seen = 0;
  int cyc = 0, n_chk = 0, n_err = 0;

  hp_cvtws_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .inexact(inexact), .invalid(invalid)
`ifdef HP_CVTWS_RTZ_EN
    , .rtz(rtz)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    int k = 0;
    @(negedge clk);
    in = v.f;
    in_valid = 1'b1;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout: in_ready stuck low for %h", v.f);
    end
    e.o = v.o; e.x = v.x; e.v = v.v; e.lat = v.lat; e.t = cyc;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in = 16'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || seen) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_output: got %h want none", out);
        end else begin
          cur = q.pop_front();
          seen = 1;
          check("latency", 32'(cyc - cur.t), 32'(cur.lat));
        end
      end
      if (seen) begin
        check("out", out, cur.o);
        check("inexact", {31'b0, inexact}, {31'b0, cur.x});
        check("invalid", {31'b0, invalid}, {31'b0, cur.v});
        check("in_ready_busy", {31'b0, in_ready}, 32'd0);
      end
      if (out_ready) seen = 0;
    end
  end

  vec_t vecs[] = '{
    '{16'h3F80, 32'h00000001, 1'b0, 1'b0, 2},
    '{16'hBFC0, 32'hFFFFFFFE, 1'b1, 1'b0, 2},
    '{16'h4020, 32'h00000002, 1'b1, 1'b0, 3},
    '{16'h4060, 32'h00000004, 1'b1, 1'b0, 3},
    '{16'h3F00, 32'h00000000, 1'b1, 1'b0, 3},
    '{16'hC040, 32'hFFFFFFFD, 1'b0, 1'b0, 3},
    '{16'h4E80, 32'h40000000, 1'b0, 1'b0, 32},
    '{16'hCF00, 32'h80000000, 1'b0, 1'b0, 1},
    '{16'h4F00, 32'h7FFFFFFF, 1'b0, 1'b1, 1},
    '{16'hCF01, 32'h80000000, 1'b0, 1'b1, 1},
    '{16'h4F80, 32'h7FFFFFFF, 1'b0, 1'b1, 1},
    '{16'h7FC0, 32'h7FFFFFFF, 1'b0, 1'b1, 1},
    '{16'hFF80, 32'h80000000, 1'b0, 1'b1, 1},
    '{16'h7F80, 32'h7FFFFFFF, 1'b0, 1'b1, 1},
    '{16'h8000, 32'h00000000, 1'b0, 1'b0, 1},
    '{16'h0001, 32'h00000000, 1'b1, 1'b0, 1},
    '{16'h3E80, 32'h00000000, 1'b1, 1'b0, 1}
  };

  initial begin
    int k;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", out, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_flags", {30'b0, inexact, invalid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    foreach (vecs[i]) send(vecs[i]);
    drain();

    // backpressure: result held while out_ready is low
    @(posedge clk);
    #1 out_ready = 1'b0;
    send('{16'h4060, 32'h00000004, 1'b1, 1'b0, 3});
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (k >= 100) begin
      n_chk++; n_err++;
      $display("FAIL bp_timeout: out_valid never rose");
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_valid", {31'b0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_hs_hold", out, 32'h00000004);
    send('{16'hBFC0, 32'hFFFFFFFE, 1'b1, 1'b0, 2});
    drain();

    // reset in the middle of a long shift
    @(negedge clk);
    in = 16'h4E80;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out", out, 32'd0);
    check("midrst_flags", {30'b0, inexact, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    send('{16'h3F80, 32'h00000001, 1'b0, 1'b0, 2});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hp_cvtws_seq.md
Name: hp_cvtws_seq

Overview:
Sequential converter from bfloat-style float (1 sign, NEXP exponent, NSIG fraction bits) to a signed INTn-bit two's-complement integer. It is the inverse of the int-to-float path in the FPU.
- Iterative single-bit shifter under an FSM; one conversion in flight at a time.
- valid/ready on input and output; IEEE invalid and inexact flags.

Parameters:
INTn, 32, integer result width (INTn > NSIG+1)
NEXP, 8, exponent width; BIAS = 2^(NEXP-1)-1
NSIG, 7, stored fraction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  block can accept operand
in  in  NEXP+NSIG+1  float operand {sign, exp, frac}
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  INTn  signed integer result
inexact  out  1  result differs from operand (valid with out_valid)
invalid  out  1  NaN / Inf / out of range (valid with out_valid)

Behaviour:
- Reset (async, any state, including mid-conversion): state=IDLE, out=0, out_valid=0, inexact=0, invalid=0. in_ready=1 once reset deasserts. Any in-flight operand is discarded.
- FSM states: IDLE, SHIFT, ROUND, DONE. in_ready = (state==IDLE). Accept occurs when in_valid & in_ready at cycle T.
- Decode at accept, with e = exp - BIAS:
  - exp==0: result 0, inexact = |frac|, invalid=0. Subnormals and +/-0 are treated this way.
  - exp all-ones, frac!=0 (NaN): out = 2^(INTn-1)-1, invalid=1.
  - exp all-ones, frac==0 (+/-Inf): saturate to max (+) or min (-), invalid=1.
  - e == INTn-1 with sign=1 and frac==0: out = -2^(INTn-1) exactly, no flags.
  - Otherwise e >= INTn-1: saturate by sign, invalid=1.
  - e <= -2 (|x| < 0.5): out=0, inexact=1.
  - All special cases above go directly to DONE; out_valid first high at T+1.
- Normal path:
  - acc = {0..0, 1, frac}, with NSIG fraction bits below the binary point; sticky=0.
  - Shift count n = e for e >= 0 (shift left), or n = 1 for e = -1 (shift right; the shifted-out bit ORs into sticky).
  - SHIFT runs one bit per cycle for n cycles (skipped when n=0). Then ROUND for 1 cycle. out_valid first high at T+2+n.
- ROUND:
  - Integer part = acc >> NSIG. guard = acc[NSIG-1]. rest = |acc[NSIG-2:0] | sticky.
  - Round-to-nearest-even: increment when guard & (rest | lsb).
  - inexact = guard | rest.
  - Negate when sign=1. A -0 result outputs 0.
  - If the rounded magnitude exceeds the range, saturate and set invalid. This cannot occur for default parameters but must be implemented.
- DONE: out, inexact and invalid are held stable while out_valid=1 and out_ready=0. On out_valid & out_ready: out_valid=0 next cycle, state=IDLE, and out and flags retain their last values. A new accept is possible in the cycle after the handshake.
- Flags: invalid=1 forces inexact=0.
- in is sampled only at accept; changes on in at other times have no effect.

Optional Feature:
Macro HP_CVTWS_RTZ_EN.
- Defined: adds input port rtz (1 bit), sampled at accept. rtz=1 selects round-toward-zero: no increment, inexact still reported, and the e <= -2 and e = -1 cases both give 0. rtz=0 gives RNE.
- Undefined: port absent; RNE only.

Test Plan:
- 0x3F80 (1.0) at T, out_ready=1 -> out=1, flags 0, out_valid at T+2. 0xBFC0 (-1.5) -> out=0xFFFFFFFE (-2), inexact=1, T+2.
- 0x4020 (2.5) -> 2, inexact=1, out_valid at T+3. 0x4060 (3.5) -> 4, inexact=1. 0x3F00 (0.5) -> 0, inexact=1, T+3.
- 0x4E80 (2^30) -> 0x40000000, no flags, out_valid at T+32. 0xCF00 (-2^31) -> 0x80000000, no flags, T+1. 0x4F00 -> 0x7FFFFFFF, invalid=1, T+1.
- 0x7FC0 (NaN) -> 0x7FFFFFFF, invalid=1, inexact=0. 0xFF80 (-Inf) -> 0x80000000, invalid=1. 0x8000 -> 0, no flags. 0x0001 -> 0, inexact=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out and flags stable, in_ready=0. Release -> handshake, then next operand accepted one cycle later.
- Reset: assert rst_n=0 mid-SHIFT of 0x4E80 -> immediate out_valid=0, out=0, flags 0. After release, in_ready=1 and 0x3F80 converts to 1 normally.
